// File: rtl/arbiter_iwrr_prog.sv
// Interleaved weighted round-robin arbiter with runtime-programmable weights.
// Weight writes are shadowed and committed to the active set only at round wrap or while idle.
module arbiter_iwrr_prog #(
    parameter int unsigned                   P_REQUESTER_NUM = 3,
    parameter int unsigned                   P_WEIGHT_W      = 4,
    parameter logic [0:P_REQUESTER_NUM*32-1] P_WEIGHT_INIT   = {32'd5, 32'd3, 32'd2}
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [P_REQUESTER_NUM-1:0]         req_i,
    input  logic                               grant_ready_i,
    output logic [P_REQUESTER_NUM-1:0]         grant_valid_o,
    output logic [$clog2(P_REQUESTER_NUM)-1:0] grant_idx_o,
    input  logic                               cfg_wr_i,
    input  logic [$clog2(P_REQUESTER_NUM)-1:0] cfg_idx_i,
    input  logic [P_WEIGHT_W-1:0]              cfg_weight_i,
    output logic [P_WEIGHT_W-1:0]              round_o
);
    localparam int unsigned N     = P_REQUESTER_NUM;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned PTR_W = $clog2(N + 1);
    localparam int unsigned WW    = P_WEIGHT_W;

    logic [WW-1:0]    w_q [N];
    logic [WW-1:0]    p_q [N];
    logic [WW-1:0]    rnd_q;
    logic [PTR_W-1:0] ptr_q;

    logic             load_c;
    logic             found_cur_c;
    logic             found_nxt_c;
    logic             higher_c;
    logic             commit_c;
    logic [IDX_W-1:0] idx_cur_c;
    logic [IDX_W-1:0] idx_nxt_c;
    logic [IDX_W-1:0] sel_idx_c;
    logic [WW-1:0]    nxt_rnd_c;
    logic [WW-1:0]    sel_rnd_c;
    logic [N-1:0]     sel_onehot_c;

    assign round_o = rnd_q;

    // Grant search: rest of the current round first, then the first slot of the following round.
    always_comb begin
        load_c       = !(|grant_valid_o) || grant_ready_i;
        found_cur_c  = 1'b0;
        found_nxt_c  = 1'b0;
        higher_c     = 1'b0;
        idx_cur_c    = '0;
        idx_nxt_c    = '0;
        sel_onehot_c = '0;

        for (int i = 0; i < int'(N); i++) begin
            if (req_i[i] && (w_q[i] > rnd_q)) begin
                higher_c = 1'b1;
            end
        end
        nxt_rnd_c = higher_c ? (rnd_q + WW'(1)) : WW'(1);

        for (int i = 0; i < int'(N); i++) begin
            if (!found_cur_c && req_i[i] && (w_q[i] >= rnd_q) && (PTR_W'(i) >= ptr_q)) begin
                found_cur_c = 1'b1;
                idx_cur_c   = IDX_W'(i);
            end
            if (!found_nxt_c && req_i[i] && (w_q[i] >= nxt_rnd_c)) begin
                found_nxt_c = 1'b1;
                idx_nxt_c   = IDX_W'(i);
            end
        end

        sel_idx_c = found_cur_c ? idx_cur_c : idx_nxt_c;
        sel_rnd_c = found_cur_c ? rnd_q : nxt_rnd_c;
        for (int i = 0; i < int'(N); i++) begin
            sel_onehot_c[i] = (sel_idx_c == IDX_W'(i));
        end

        // Commit on a wrap-path grant or on an idle load.
        commit_c = load_c && !found_cur_c && (!found_nxt_c || (nxt_rnd_c == WW'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_valid_o <= '0;
            grant_idx_o   <= '0;
            rnd_q         <= WW'(1);
            ptr_q         <= '0;
            for (int i = 0; i < int'(N); i++) begin
                w_q[i] <= WW'(P_WEIGHT_INIT[i*32 +: 32]);
                p_q[i] <= WW'(P_WEIGHT_INIT[i*32 +: 32]);
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (cfg_wr_i && (cfg_idx_i == IDX_W'(i))) begin
                    p_q[i] <= cfg_weight_i;
                end
            end
            // Active weights take the pending values as they stood before this edge.
            if (commit_c) begin
                w_q <= p_q;
            end
            if (load_c) begin
                if (found_cur_c || found_nxt_c) begin
                    grant_valid_o <= sel_onehot_c;
                    grant_idx_o   <= sel_idx_c;
                    ptr_q         <= PTR_W'(sel_idx_c) + PTR_W'(1);
                    rnd_q         <= sel_rnd_c;
                end else begin
                    grant_valid_o <= '0;
                end
            end
        end
    end

endmodule
